// File: rtl/allocate_memory_ram.sv
// allocate_memory_ram: 1024x32 RAM with a next-fit slot allocator driven by an occupancy bitmap
module allocate_memory_ram (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  ram_address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  input  logic        enable,
  output logic        adr_found,
  output logic [9:0]  address,
  output logic        alloc_full
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE, FULL} state_t;
  state_t state, state_n;
  logic [31:0] mem [1024];
  logic [1023:0] occ;
  logic [9:0] ptr, ptr_n, cnt, cnt_n, address_n, ptr_inc;
  logic take;
  assign ptr_inc = ptr == 10'd1023 ? 10'd1 : ptr + 10'd1;
  assign adr_found = state == DONE;
  assign alloc_full = state == FULL;
  always_ff @(posedge clock)
    if (!reset && wren) mem[ram_address] <= data;
  always_ff @(posedge clock)
    q <= reset ? 32'd0 : mem[ram_address];
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr <= 10'd1;
      cnt <= 10'd0;
      address <= 10'd0;
      occ <= {{1023{1'b0}}, 1'b1};
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      address <= address_n;
      if (take) occ[ptr] <= 1'b1;
      if (wren) occ[ram_address] <= data[31];
      occ[0] <= 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    address_n = address;
    take = 1'b0;
    case (state)
      IDLE: begin
        state_n = enable ? SCAN : IDLE;
        cnt_n = 10'd0;
      end
      SCAN: begin
        if (!enable) state_n = IDLE;
        else begin
          ptr_n = ptr_inc;
          if (!occ[ptr]) begin
            take = 1'b1;
            address_n = ptr;
            state_n = DONE;
          end else if (cnt == 10'd1022) begin
            address_n = 10'd0;
            state_n = FULL;
          end else cnt_n = cnt + 10'd1;
        end
      end
      DONE, FULL: state_n = enable ? state : IDLE;
    endcase
  end
endmodule

// File: tb/tb_allocate_memory_ram.sv
// tb_allocate_memory_ram: randomized and directed checks of the RAM and allocator against a reference model
module tb_allocate_memory_ram;
  logic clock = 1'b0;
  logic reset, wren, enable;
  logic [9:0] ram_address;
  logic [31:0] data;
  logic [31:0] q;
  logic adr_found, alloc_full;
  logic [9:0] address;
  int checks = 0;
  int failures = 0;
  bit mocc [1024];
  int mptr;
  logic [31:0] mmem [1024];
  bit mval [1024];

  allocate_memory_ram dut (
    .clock(clock), .reset(reset), .ram_address(ram_address), .data(data), .wren(wren),
    .q(q), .enable(enable), .adr_found(adr_found), .address(address), .alloc_full(alloc_full)
  );

  always #5 clock = ~clock;

  task step;
    @(posedge clock);
    #1;
  endtask

  task model_reset;
    for (int i = 0; i < 1024; i++) mocc[i] = 1'b0;
    mocc[0] = 1'b1;
    mptr = 1;
  endtask

  task model_alloc(output logic [9:0] ea, output logic ef, output int en);
    ea = 10'd0;
    ef = 1'b0;
    en = 1024;
    for (int k = 0; k < 1023; k++) begin
      int c;
      c = ((mptr - 1 + k) % 1023) + 1;
      if (!mocc[c]) begin
        mocc[c] = 1'b1;
        mptr = c == 1023 ? 1 : c + 1;
        ea = 10'(c);
        ef = 1'b1;
        en = k + 2;
        break;
      end
    end
  endtask

  task do_reset;
    reset = 1'b1;
    wren = 1'b0;
    enable = 1'b0;
    step;
    reset = 1'b0;
    model_reset;
  endtask

  task do_write(input logic [9:0] a, input logic [31:0] d);
    ram_address = a;
    data = d;
    wren = 1'b1;
    step;
    wren = 1'b0;
    mmem[a] = d;
    mval[a] = 1'b1;
    if (a != 10'd0) mocc[a] = d[31];
  endtask

  task do_request(output logic [9:0] ga, output logic gf, output logic gu, output int n);
    enable = 1'b1;
    step;
    n = 1;
    while (!(adr_found || alloc_full) && n < 1100) begin
      step;
      n++;
    end
    ga = address;
    gf = adr_found;
    gu = alloc_full;
    enable = 1'b0;
    step;
  endtask

  task test_reset;
    reset = 1'b1;
    enable = 1'b1;
    wren = 1'b0;
    ram_address = 10'd0;
    data = 32'd0;
    step;
    reset = 1'b0;
    enable = 1'b0;
    model_reset;
    checks++;
    if ({q, adr_found, alloc_full, address} !== 44'd0) begin
      failures++;
      $display("FAIL reset_state: q=%h found=%b full=%b addr=%0d, want all zero", q, adr_found, alloc_full, address);
    end
    step;
    checks++;
    if (adr_found !== 1'b0 || alloc_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: found=%b full=%b, want 0 0", adr_found, alloc_full);
    end
  endtask

  task test_basic;
    logic [9:0] ea, ga;
    logic ef, gf, gu;
    int en, n;
    model_alloc(ea, ef, en);
    enable = 1'b1;
    step;
    checks++;
    if (adr_found !== 1'b0) begin
      failures++;
      $display("FAIL first_edge: found=%b, want 0", adr_found);
    end
    step;
    checks++;
    if (adr_found !== 1'b1 || address !== ea || ea !== 10'd1) begin
      failures++;
      $display("FAIL first_alloc: found=%b addr=%0d, want 1 addr=%0d (model %0d)", adr_found, address, 1, ea);
    end
    step;
    step;
    checks++;
    if (adr_found !== 1'b1 || alloc_full !== 1'b0 || address !== ea) begin
      failures++;
      $display("FAIL hold_done: found=%b full=%b addr=%0d, want 1 0 %0d", adr_found, alloc_full, address, ea);
    end
    enable = 1'b0;
    step;
    checks++;
    if (adr_found !== 1'b0 || alloc_full !== 1'b0) begin
      failures++;
      $display("FAIL release: found=%b full=%b, want 0 0", adr_found, alloc_full);
    end
    do_request(ga, gf, gu, n);
    model_alloc(ea, ef, en);
    checks++;
    if (ga !== ea || gf !== ef || gu !== !ef || n !== en || ea !== 10'd2) begin
      failures++;
      $display("FAIL second_alloc: addr=%0d found=%b full=%b edges=%0d, want addr=%0d found=%b edges=%0d", ga, gf, gu, n, ea, ef, en);
    end
  endtask

  task test_ram_access;
    logic [9:0] ea, ga;
    logic ef, gf, gu;
    int en, n;
    do_write(10'd5, 32'h8035_0003);
    ram_address = 10'd5;
    step;
    checks++;
    if (q !== 32'h8035_0003) begin
      failures++;
      $display("FAIL read_back: q=%h, want 80350003", q);
    end
    for (int i = 0; i < 4; i++) begin
      do_request(ga, gf, gu, n);
      model_alloc(ea, ef, en);
      checks++;
      if (ga !== ea || gf !== ef || gu !== !ef || n !== en || ga == 10'd5) begin
        failures++;
        $display("FAIL skip_used: addr=%0d found=%b edges=%0d, want addr=%0d found=%b edges=%0d", ga, gf, n, ea, ef, en);
      end
    end
    do_write(10'd600, 32'h0000_1234);
    ram_address = 10'd600;
    data = 32'hAAAA_AAAA;
    wren = 1'b1;
    step;
    checks++;
    if (q !== 32'h0000_1234) begin
      failures++;
      $display("FAIL rdw_old: q=%h, want 00001234", q);
    end
    data = 32'h5555_5555;
    step;
    checks++;
    if (q !== 32'hAAAA_AAAA) begin
      failures++;
      $display("FAIL rdw_second: q=%h, want aaaaaaaa", q);
    end
    wren = 1'b0;
    step;
    checks++;
    if (q !== 32'h5555_5555) begin
      failures++;
      $display("FAIL rdw_new: q=%h, want 55555555", q);
    end
    mmem[600] = 32'h5555_5555;
    mocc[600] = 1'b0;
  endtask

  task test_wrap;
    logic [9:0] ea, ga;
    logic ef, gf, gu;
    int en, n, bad;
    do_reset;
    for (int i = 1; i <= 3; i++) begin
      do_request(ga, gf, gu, n);
      model_alloc(ea, ef, en);
      checks++;
      if (ga !== ea || gf !== ef || n !== en || ga !== 10'(i)) begin
        failures++;
        $display("FAIL alloc_%0d: addr=%0d found=%b edges=%0d, want addr=%0d edges=%0d", i, ga, gf, n, i, en);
      end
    end
    do_write(10'd2, 32'h0000_0000);
    do_request(ga, gf, gu, n);
    model_alloc(ea, ef, en);
    checks++;
    if (ga !== ea || gf !== ef || ga !== 10'd4) begin
      failures++;
      $display("FAIL next_fit: addr=%0d found=%b, want addr=4", ga, gf);
    end
    bad = 0;
    while (ea != 10'd1023 && bad < 3) begin
      do_request(ga, gf, gu, n);
      model_alloc(ea, ef, en);
      checks++;
      if (ga !== ea || gf !== ef || gu !== !ef || n !== en) begin
        failures++;
        bad++;
        $display("FAIL fill_%0d: addr=%0d found=%b edges=%0d, want addr=%0d edges=%0d", ea, ga, gf, n, ea, en);
      end
    end
    do_request(ga, gf, gu, n);
    model_alloc(ea, ef, en);
    checks++;
    if (ga !== 10'd2 || gf !== 1'b1 || ea !== 10'd2 || n !== en) begin
      failures++;
      $display("FAIL wrap: addr=%0d found=%b edges=%0d, want addr=2 edges=%0d", ga, gf, n, en);
    end
  endtask

  task test_full;
    logic [9:0] ea, ga;
    logic ef, gf, gu;
    int en, n;
    do_request(ga, gf, gu, n);
    model_alloc(ea, ef, en);
    checks++;
    if (gf !== 1'b0 || gu !== 1'b1 || ga !== 10'd0 || n !== 1024 || ef !== 1'b0) begin
      failures++;
      $display("FAIL full: addr=%0d found=%b full=%b edges=%0d, want addr=0 found=0 full=1 edges=1024", ga, gf, gu, n);
    end
  endtask

  task test_reset_mid_scan;
    logic [9:0] ea, ga;
    logic ef, gf, gu;
    int en, n;
    do_write(10'd7, 32'h8000_0007);
    enable = 1'b1;
    repeat (10) step;
    reset = 1'b1;
    wren = 1'b1;
    ram_address = 10'd7;
    data = 32'h1234_5678;
    step;
    reset = 1'b0;
    wren = 1'b0;
    enable = 1'b0;
    model_reset;
    checks++;
    if ({q, adr_found, alloc_full, address} !== 44'd0) begin
      failures++;
      $display("FAIL mid_scan_reset: q=%h found=%b full=%b addr=%0d, want all zero", q, adr_found, alloc_full, address);
    end
    step;
    checks++;
    if (q !== 32'h8000_0007) begin
      failures++;
      $display("FAIL write_in_reset: q=%h, want 80000007", q);
    end
    do_request(ga, gf, gu, n);
    model_alloc(ea, ef, en);
    checks++;
    if (ga !== 10'd1 || gf !== 1'b1 || n !== 2) begin
      failures++;
      $display("FAIL after_reset: addr=%0d found=%b edges=%0d, want addr=1 edges=2", ga, gf, n);
    end
    enable = 1'b1;
    step;
    enable = 1'b0;
    step;
    step;
    checks++;
    if (adr_found !== 1'b0 || alloc_full !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: found=%b full=%b, want 0 0", adr_found, alloc_full);
    end
    do_request(ga, gf, gu, n);
    model_alloc(ea, ef, en);
    checks++;
    if (ga !== 10'd2 || ea !== 10'd2 || gf !== 1'b1 || n !== en) begin
      failures++;
      $display("FAIL abort_no_reserve: addr=%0d found=%b edges=%0d, want addr=2 edges=%0d", ga, gf, n, en);
    end
  endtask

  task test_random;
    logic [9:0] ea, ga, a;
    logic ef, gf, gu;
    int en, n, bad;
    bad = 0;
    do_reset;
    for (int i = 0; i < 300 && bad < 5; i++) begin
      case ($urandom_range(0, 2))
        0: do_write(10'($urandom_range(0, 1023)), $urandom & 32'h803F_03FF);
        1: begin
          a = 10'($urandom_range(0, 1023));
          ram_address = a;
          step;
          if (mval[a]) begin
            checks++;
            if (q !== mmem[a]) begin
              failures++;
              bad++;
              $display("FAIL rand_read_%0d: q=%h, want %h", a, q, mmem[a]);
            end
          end
        end
        default: begin
          do_request(ga, gf, gu, n);
          model_alloc(ea, ef, en);
          checks++;
          if (ga !== ea || gf !== ef || gu !== !ef || n !== en) begin
            failures++;
            bad++;
            $display("FAIL rand_alloc: addr=%0d found=%b full=%b edges=%0d, want addr=%0d found=%b edges=%0d", ga, gf, gu, n, ea, ef, en);
          end
        end
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mval[i] = 1'b0;
    test_reset;
    test_basic;
    test_ram_access;
    test_wrap;
    test_full;
    test_reset_mid_scan;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/allocate_memory_ram.md
ALLOCATE_MEMORY_RAM -- requirements
Module: allocate_memory_ram

Interface
REQ-001 Parameters: none; geometry fixed at 1024 words x 32 bits, 10-bit addresses.
REQ-002 One clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-003 clock  in  1  rising-edge clock for all state, RAM and allocator.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ram_address  in  10  RAM read/write address.
REQ-006 data  in  32  RAM write data; bit31 = in-use flag, [21:20] suit, [19:16] value, [9:0] next pointer, other bits 0 by convention.
REQ-007 wren  in  1  RAM write enable.
REQ-008 q  out  32  registered RAM read data.
REQ-009 enable  in  1  allocation request, level-sensitive.
REQ-010 adr_found  out  1  allocation succeeded; address valid.
REQ-011 address  out  10  allocated slot address.
REQ-012 alloc_full  out  1  allocation failed, no free slot.

Function
REQ-013 RAM: on a clock edge with wren=1, mem[ram_address] <= data; q <= mem[ram_address] every edge, giving 1-cycle read latency.
REQ-014 Read-during-write to the same address returns the old word on q.
REQ-015 RAM contents are not cleared by reset; q resets to 0.
REQ-016 Occupancy bitmap: 1024 bits, with occ[i]=1 meaning slot i is in use or reserved.
REQ-017 Every RAM write sets occ[ram_address] <= data[31].
REQ-018 Address 0 is the null pointer: occ[0] is forced to 1, and 0 is never allocated.
REQ-019 The allocator FSM has states IDLE, SCAN, DONE and FULL.
REQ-020 IDLE: adr_found=0 and alloc_full=0. If enable=1 at an edge, go to SCAN with cnt=0.
REQ-021 SCAN: test one candidate per cycle, occ[ptr].
- If free: address<=ptr, occ[ptr]<=1 (reserve), adr_found<=1, go to DONE.
- Else: cnt<=cnt+1.
- In both cases ptr advances: 1023 wraps to 1, skipping 0.
REQ-022 SCAN: when 1023 candidates have been tested with none free, go to FULL with alloc_full<=1, address<=0, adr_found=0.
REQ-023 DONE and FULL hold their outputs while enable=1. Return to IDLE on the first edge with enable=0, clearing adr_found and alloc_full.
REQ-024 Latency: if the first candidate is free, adr_found is high after the 2nd edge counted from the edge that samples enable=1. A full memory resolves after 1024 edges.
REQ-025 Deasserting enable during SCAN aborts the scan and returns to IDLE; no slot is reserved.
REQ-026 A RAM write and a scan test of the same slot in one cycle: the scan uses the pre-edge occ value, and the RAM write's occ update wins.
REQ-027 Only one reservation occurs per request, and a reserved slot is never returned again until a write clears its bit31.

Reset
REQ-028 On reset: FSM=IDLE, ptr=1, cnt=0, occ cleared except occ[0]=1, adr_found=0, alloc_full=0, address=0, q=0.
REQ-029 Reset wins over enable and wren in the same cycle. During reset no RAM write occurs and no reservation is made.

Verification
REQ-030 After reset, hold enable=1 -> adr_found=1, address=1 after 2 edges. Drop enable for 1 cycle, request again -> address=2.
REQ-031 wren=1, ram_address=5, data=0x8035_0003; next cycle read address 5 -> q=0x8035_0003 one edge later. A later request does not return 5.
REQ-032 Allocate 1,2,3. Write 0x0000_0000 to address 2. Next request -> 4. Allocate up to 1023; the next request wraps to 2.
REQ-033 Allocate all 1023 slots, then request -> alloc_full=1, adr_found=0, address=0 after 1024 edges.
REQ-034 Assert reset mid-SCAN -> IDLE, outputs 0, occ cleared. Next request -> address=1.
REQ-035 Write 0xAAAA_AAAA then 0x5555_5555 to the same address on consecutive edges while reading it -> q shows old data, then new data.
